// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a single-cycle instruction memory
// and buffers fetched {instr, pc} pairs in a small FIFO toward decode.
// Optional macro IFU_PERF_CNT_EN adds a saturating fetch back-pressure counter
// on output port fetch_stall_cnt.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_stall_cnt
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] instr_q [DEPTH];
    logic [DATA_W-1:0] instr_d [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d [DEPTH];

    logic full;
    logic pop;
    logic push;

    // Head of the FIFO is read straight out of the storage flops.
    assign out_valid = (count_q != '0);
    assign out_instr = instr_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign imem_addr = fetch_pc_q;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = out_valid & out_ready;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign push = fetch_en & ~redirect_valid & (~full | pop);

    // Next-state for PC, pointers, occupancy and entry storage.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        instr_d    = instr_q;
        pc_mem_d   = pc_mem_q;

        if (redirect_valid) begin
            // Flush everything still queued; a same-cycle pop is already consumed.
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q]  = imem_rdata;
                pc_mem_d[wr_ptr_q] = fetch_pc_q;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
                fetch_pc_d         = fetch_pc_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i]  <= '0;
                pc_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            instr_q    <= instr_d;
            pc_mem_q   <= pc_mem_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // Fetch wanted but the FIFO could not take the word.
    assign stall           = fetch_en & ~redirect_valid & ~push;
    assign fetch_stall_cnt = stall_cnt_q;

    // Saturating back-pressure counter next-state.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Back-pressure counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule
